// File: rtl/sha256_msg_padder_pkg.sv
// Shared types and helpers for the SHA-256 message padder: word/block types,
// the padding constant, block-count helper and the padder FSM state encoding.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:15] block_t;

  localparam word_t PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Blocks needed for n words plus the pad word and the two length words.
  function automatic int num_blocks(int n);
    return (n + 32'sd2) / 32'sd16 + 32'sd1;
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Block delivery handshake between the padder and the compression stage.
interface sha256_msg_padder_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  modport master (output blk_valid, output blk_data, output blk_last, input blk_ready);
  modport slave  (input blk_valid, input blk_data, input blk_last, output blk_ready);
endinterface

// File: rtl/sha256_msg_padder_pad_word.sv
// Selects the content of padded-message word j: message data, pad marker,
// zero fill or one half of the 64-bit big-endian bit length.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] j,
  input  logic [31:0] n,
  input  logic [31:0] t,
  input  word_t       mem_rd_data,
  output word_t       value
);

  logic [63:0] bit_len;

  // Word selection by position within the padded message.
  always_comb begin
    bit_len = {32'd0, n} << 6'd5;
    if (j < n) begin
      value = mem_rd_data;
    end else if (j == n) begin
      value = PAD_WORD;
    end else if (j == t - 32'd2) begin
      value = bit_len[63:32];
    end else if (j == t - 32'd1) begin
      value = bit_len[31:0];
    end else begin
      value = 32'd0;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads an N-word message from synchronous RAM, appends SHA-256 padding and
// presents complete 512-bit blocks on a valid/ready interface.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   msg_addr,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [31:0]         mem_rd_data,
  sha256_msg_padder_if.master blk,
  output logic                busy,
  output logic                done
);

  localparam logic [31:0] N  = 32'(NUM_OF_WORDS);
  localparam int          NB = num_blocks(NUM_OF_WORDS);
  localparam logic [31:0] T  = 32'(16 * NB);

  state_t             state;
  logic [4:0]         lc;
  logic [15:0]        blk_idx;
  logic [ADDR_W-1:0]  base;
  block_t             buffer;
  logic               valid;
  logic               last;

  logic [31:0]        blk_base;
  logic [31:0]        j_wr;
  logic [3:0]         wr_idx;
  word_t              pad_value;
  logic               issue;
  logic [31:0]        issue_j;
  logic [ADDR_W-1:0]  issue_base;

  assign blk_base = 32'({blk_idx, 4'h0});
  assign j_wr     = blk_base + 32'(lc) - 32'd1;
  // lc=16 wraps to index 15, the final word of the block.
  assign wr_idx   = 4'(lc - 5'd1);

  assign blk.blk_valid = valid;
  assign blk.blk_data  = buffer;
  assign blk.blk_last  = last;

  sha256_pad_word u_pad_word (
    .j           (j_wr),
    .n           (N),
    .t           (T),
    .mem_rd_data (mem_rd_data),
    .value       (pad_value)
  );

  // Read address for the word of the next cycle; the RAM output is registered.
  always_comb begin
    issue      = 1'b0;
    issue_j    = 32'd0;
    issue_base = base;
    case (state)
      IDLE: begin
        if (start) begin
          issue      = 1'b1;
          issue_base = msg_addr;
        end else begin
          issue = 1'b0;
        end
      end
      LOAD: begin
        if (lc < 5'd15) begin
          issue   = 1'b1;
          issue_j = blk_base + 32'(lc) + 32'd1;
        end else begin
          issue = 1'b0;
        end
      end
      OUT: begin
        if (blk.blk_ready && !last) begin
          issue   = 1'b1;
          issue_j = blk_base + 32'd16;
        end else begin
          issue = 1'b0;
        end
      end
      default: issue = 1'b0;
    endcase
  end

  // Control FSM, counters, block buffer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lc        <= 5'd0;
      blk_idx   <= 16'd0;
      base      <= '0;
      buffer    <= '0;
      valid     <= 1'b0;
      last      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (issue) begin
        mem_rd_en <= (issue_j < N);
        mem_addr  <= issue_base + issue_j[ADDR_W-1:0];
      end else begin
        mem_rd_en <= 1'b0;
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base    <= msg_addr;
            blk_idx <= 16'd0;
            lc      <= 5'd0;
            busy    <= 1'b1;
            state   <= LOAD;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          if (lc != 5'd0) begin
            buffer[wr_idx] <= pad_value;
          end else begin
            buffer <= buffer;
          end
          if (lc == 5'd16) begin
            valid <= 1'b1;
            last  <= (blk_idx == 16'(NB - 1));
            state <= OUT;
          end else begin
            lc <= lc + 5'd1;
          end
        end
        OUT: begin
          if (blk.blk_ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              blk_idx <= blk_idx + 16'd1;
              lc      <= 5'd0;
              state   <= LOAD;
            end
          end else begin
            valid <= 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench: five padder instances with different message lengths,
// each backed by a synchronous RAM model with address-derived contents.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  localparam int ND = 5;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start    [ND];
  logic [15:0]  msg_addr [ND];
  logic         ready    [ND];
  logic         valid    [ND];
  logic         last     [ND];
  logic         rd_en    [ND];
  logic         busy     [ND];
  logic         done     [ND];
  logic [15:0]  addr     [ND];
  logic [511:0] data     [ND];

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] rd_addrs[$];

  function automatic int n_of(int k);
    case (k)
      0: return 1;
      1: return 20;
      2: return 13;
      3: return 14;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] mem_val(logic [15:0] a);
    if (a == 16'h0100) return 32'h6162_6364;
    return {~a, a};
  endfunction

  function automatic logic [31:0] exp_word(int n, logic [15:0] a, int j);
    int t;
    logic [63:0] bl;
    t  = 16 * ((n + 2) / 16 + 1);
    bl = 64'(n) << 5;
    if (j < n) return mem_val(a + 16'(j));
    if (j == n) return 32'h8000_0000;
    if (j == t - 2) return bl[63:32];
    if (j == t - 1) return bl[31:0];
    return 32'h0;
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sha256_msg_padder_if bif ();
    logic [31:0] rd_data;
    logic        m_rd_en;
    logic [15:0] m_addr;
    logic        m_busy;
    logic        m_done;

    sha256_msg_padder #(.NUM_OF_WORDS(n_of(g)), .ADDR_W(16)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start[g]),
      .msg_addr    (msg_addr[g]),
      .mem_rd_en   (m_rd_en),
      .mem_addr    (m_addr),
      .mem_rd_data (rd_data),
      .blk         (bif.master),
      .busy        (m_busy),
      .done        (m_done)
    );

    // Poison data on idle cycles so a missing read or wrong pad select shows.
    always_ff @(posedge clk) rd_data <= m_rd_en ? mem_val(m_addr) : 32'hDEAD_BEEF;

    assign bif.blk_ready = ready[g];
    assign valid[g] = bif.blk_valid;
    assign last[g]  = bif.blk_last;
    assign data[g]  = bif.blk_data;
    assign rd_en[g] = m_rd_en;
    assign addr[g]  = m_addr;
    assign busy[g]  = m_busy;
    assign done[g]  = m_done;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample_rd(input int k);
    if (rd_en[k]) rd_addrs.push_back(addr[k]);
  endtask

  task automatic wait_valid(input int k, output int cyc);
    cyc = 1;
    sample_rd(k);
    while (!valid[k] && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      sample_rd(k);
    end
  endtask

  task automatic check_block(input int k, input logic [15:0] a, input int b);
    for (int w = 0; w < 16; w++)
      check_val($sformatf("k%0d_b%0d_w%0d", k, b, w), data[k][511 - 32*w -: 32],
                exp_word(n_of(k), a, 16*b + w));
  endtask

  task automatic run_msg(input int k, input logic [15:0] a, input int nb, input bit hold);
    int cyc;
    rd_addrs.delete();
    msg_addr[k] = a;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      wait_valid(k, cyc);
      check_val($sformatf("k%0d_b%0d_latency", k, b), 32'(cyc), 32'd18);
      check_val($sformatf("k%0d_b%0d_last", k, b), 32'(last[k]), 32'(b == nb - 1));
      check_block(k, a, b);
      if (hold && b == 0) begin
        for (int i = 0; i < 5; i++) begin
          check_val("hold_valid", 32'(valid[k]), 32'd1);
          check_val("hold_w0", data[k][511:480], exp_word(n_of(k), a, 0));
          check_val("hold_w15", data[k][31:0], exp_word(n_of(k), a, 15));
          check_val("hold_last", 32'(last[k]), 32'd0);
          check_val("hold_rd_en", 32'(rd_en[k]), 32'd0);
          check_val("hold_busy", 32'(busy[k]), 32'd1);
          start[k] = (i == 1);
          @(posedge clk); #1;
          start[k] = 1'b0;
        end
        check_block(k, a, b);
      end
      ready[k] = 1'b1;
      @(posedge clk); #1;
      ready[k] = 1'b0;
      check_val($sformatf("k%0d_b%0d_valid_drop", k, b), 32'(valid[k]), 32'd0);
    end
    check_val($sformatf("k%0d_done_hi", k), 32'(done[k]), 32'd1);
    check_val($sformatf("k%0d_busy_fin", k), 32'(busy[k]), 32'd1);
    @(posedge clk); #1;
    check_val($sformatf("k%0d_done_lo", k), 32'(done[k]), 32'd0);
    check_val($sformatf("k%0d_busy_lo", k), 32'(busy[k]), 32'd0);
    check_val($sformatf("k%0d_rd_count", k), 32'(rd_addrs.size()), 32'(n_of(k)));
  endtask

  task automatic check_reset_vals(input int k);
    check_val("rst_valid", 32'(valid[k]), 32'd0);
    check_val("rst_last", 32'(last[k]), 32'd0);
    check_val("rst_rd_en", 32'(rd_en[k]), 32'd0);
    check_val("rst_addr", 32'(addr[k]), 32'd0);
    check_val("rst_busy", 32'(busy[k]), 32'd0);
    check_val("rst_done", 32'(done[k]), 32'd0);
    check_val("rst_data", 32'(|data[k]), 32'd0);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < ND; k++) begin
      start[k] = 1'b0;
      ready[k] = 1'b0;
      msg_addr[k] = 16'h0;
    end
    #2;
    check_reset_vals(1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // N=1: single block, hand-computed words.
    run_msg(0, 16'h0100, 1, 1'b0);

    // N=20 with back-pressure on block0 and a stray start.
    run_msg(1, 16'h0400, 2, 1'b1);

    run_msg(2, 16'h2000, 1, 1'b0);
    run_msg(3, 16'h3000, 2, 1'b0);

    // N=4 across the address wrap.
    run_msg(4, 16'hFFFE, 1, 1'b0);
    check_val("wrap_a0", 32'(rd_addrs[0]), 32'h0000_FFFE);
    check_val("wrap_a1", 32'(rd_addrs[1]), 32'h0000_FFFF);
    check_val("wrap_a2", 32'(rd_addrs[2]), 32'h0000_0000);
    check_val("wrap_a3", 32'(rd_addrs[3]), 32'h0000_0001);

    // Reset in the middle of block1 load, then restart.
    msg_addr[1] = 16'h0400;
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    wait_valid(1, cyc);
    check_val("rl_latency", 32'(cyc), 32'd18);
    ready[1] = 1'b1;
    @(posedge clk); #1;
    ready[1] = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check_val("rl_c7_addr", 32'(addr[1]), 32'h0000_0417);
    check_val("rl_c7_rd_en", 32'(rd_en[1]), 32'd0);
    check_val("rl_c7_busy", 32'(busy[1]), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals(1);
    @(posedge clk); #1;
    check_val("rl_no_done", 32'(done[1]), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_msg(1, 16'h0500, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
